// File: rtl/cordic_shift_sequencer.sv
// Iterative CORDIC rotation controller: one angle per request, x and y take turns on a single
// external arithmetic-right barrel shifter, two cycles per iteration.
//
// state   | meaning
// IDLE    | waiting for i_start; results held
// SHIFT_X | x presented to shifter, shifted x captured
// SHIFT_Y | y presented to shifter, x/y/z rotated by one micro-step
// DONE    | o_valid pulse, final results visible on o_cos/o_sin
module cordic_shift_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int ITERATIONS = 15,
  parameter int SHIFT_W    = 4,
  parameter int X_INIT     = 9949
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_angle,
  output logic                  o_busy,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_cos,
  output logic [DATA_WIDTH-1:0] o_sin,
  output logic [DATA_WIDTH-1:0] o_shf_data,
  output logic [SHIFT_W-1:0]    o_shf_amt,
  input  logic [DATA_WIDTH-1:0] i_shf_data
);

  typedef enum logic [1:0] {IDLE, SHIFT_X, SHIFT_Y, DONE} state_t;

  state_t state, state_nxt;

  logic [DATA_WIDTH-1:0] x, y, z, xs;
  logic [DATA_WIDTH-1:0] x_nxt, y_nxt, z_nxt, atan_i;
  logic [SHIFT_W-1:0]    iter;
  logic                  z_pos, last_iter;

  function automatic logic [DATA_WIDTH-1:0] atan_rom(input logic [SHIFT_W-1:0] idx);
    logic [DATA_WIDTH-1:0] v;
    case (idx)
      SHIFT_W'(0):  v = DATA_WIDTH'(12868);
      SHIFT_W'(1):  v = DATA_WIDTH'(7596);
      SHIFT_W'(2):  v = DATA_WIDTH'(4014);
      SHIFT_W'(3):  v = DATA_WIDTH'(2037);
      SHIFT_W'(4):  v = DATA_WIDTH'(1023);
      SHIFT_W'(5):  v = DATA_WIDTH'(512);
      SHIFT_W'(6):  v = DATA_WIDTH'(256);
      SHIFT_W'(7):  v = DATA_WIDTH'(128);
      SHIFT_W'(8):  v = DATA_WIDTH'(64);
      SHIFT_W'(9):  v = DATA_WIDTH'(32);
      SHIFT_W'(10): v = DATA_WIDTH'(16);
      SHIFT_W'(11): v = DATA_WIDTH'(8);
      SHIFT_W'(12): v = DATA_WIDTH'(4);
      SHIFT_W'(13): v = DATA_WIDTH'(2);
      SHIFT_W'(14): v = DATA_WIDTH'(1);
      default:      v = '0;
    endcase
    return v;
  endfunction

  // Direction comes from z at the start of the iteration; ys is the live shifter result.
  assign z_pos     = ~z[DATA_WIDTH-1];
  assign atan_i    = atan_rom(iter);
  assign x_nxt     = z_pos ? (x - i_shf_data) : (x + i_shf_data);
  assign y_nxt     = z_pos ? (y + xs) : (y - xs);
  assign z_nxt     = z_pos ? (z - atan_i) : (z + atan_i);
  assign last_iter = (iter == SHIFT_W'(ITERATIONS - 1));
  assign o_busy    = (state != IDLE);

  always_comb begin
    state_nxt  = state;
    o_shf_data = '0;
    o_shf_amt  = '0;
    o_valid    = 1'b0;
    case (state)
      IDLE:    if (i_start) state_nxt = SHIFT_X;
      SHIFT_X: begin
        o_shf_data = x;
        o_shf_amt  = iter;
        state_nxt  = SHIFT_Y;
      end
      SHIFT_Y: begin
        o_shf_data = y;
        o_shf_amt  = iter;
        state_nxt  = last_iter ? DONE : SHIFT_X;
      end
      DONE: begin
        o_valid   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      x     <= '0;
      y     <= '0;
      z     <= '0;
      xs    <= '0;
      iter  <= '0;
      o_cos <= '0;
      o_sin <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (i_start) begin
          x    <= DATA_WIDTH'(X_INIT);
          y    <= '0;
          z    <= i_angle;
          iter <= '0;
        end
        SHIFT_X: xs <= i_shf_data;
        SHIFT_Y: begin
          x <= x_nxt;
          y <= y_nxt;
          z <= z_nxt;
          // Results load on the final rotation so they are already visible during the o_valid cycle.
          if (last_iter) begin
            o_cos <= x_nxt;
            o_sin <= y_nxt;
          end else begin
            iter <= iter + SHIFT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
